// File: rtl/tmds_decoder.sv
// -----------------------------------------------------------------------------
// tmds_decoder
//
// Recovers 10-bit word alignment from a raw deserialized TMDS stream and
// decodes it. A 20-bit window {current raw word, previous raw word} is sliced
// at bit_offset. An alignment FSM (SEARCH -> VERIFY -> LOCKED) hunts for
// control tokens to find the correct offset. While locked, data words are
// decoded to pixel bytes and control tokens update hsync/vsync.
//
// Parameters:
//   SEARCH_WIN  cycles without a token before SEARCH tries the next offset
//   TOKEN_LOCK  consecutive tokens in VERIFY needed to declare lock
//   LOSS_WIN    cycles without a token in LOCKED before lock is dropped
//
// Ports:
//   clk_in        pixel clock, one raw word per rising edge
//   sys_rst       synchronous active-high reset
//   data_in       raw 10-bit word, arbitrary bit alignment
//   data_out      decoded pixel byte (0 when not a locked data word)
//   rgb_valid     high when data_out carries a decoded video word
//   hsync, vsync  C0 / C1 of the most recent control token while locked
//   locked        high while the FSM is in LOCKED
//   bit_offset    current alignment offset, 0..9
//   lock_loss_cnt saturating count of LOCKED->SEARCH transitions
//                 (present only when LOCK_LOSS_CNT_EN is defined)
//
// Optional feature macro: LOCK_LOSS_CNT_EN
// -----------------------------------------------------------------------------
module tmds_decoder #(
    parameter int SEARCH_WIN = 1024,
    parameter int TOKEN_LOCK = 8,
    parameter int LOSS_WIN   = 4096
) (
    input  logic        clk_in,
    input  logic        sys_rst,
    input  logic [9:0]  data_in,
    output logic [7:0]  data_out,
    output logic        rgb_valid,
    output logic        hsync,
    output logic        vsync,
    output logic        locked,
    output logic [3:0]  bit_offset
`ifdef LOCK_LOSS_CNT_EN
    ,
    output logic [15:0] lock_loss_cnt
`endif
);

    localparam int SW = (SEARCH_WIN > 1) ? $clog2(SEARCH_WIN) : 1;
    localparam int LW = (LOSS_WIN > 1) ? $clog2(LOSS_WIN) : 1;
    localparam int TW = $clog2(TOKEN_LOCK + 1);

    localparam logic [SW-1:0] SEARCH_LAST = SW'(SEARCH_WIN - 1);
    localparam logic [LW-1:0] LOSS_LAST   = LW'(LOSS_WIN - 1);
    localparam logic [TW-1:0] TOKEN_LAST  = TW'(TOKEN_LOCK - 1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [SW-1:0] search_cnt, search_next;
    logic [TW-1:0] verify_cnt, verify_next;
    logic [LW-1:0] loss_cnt, loss_next;
    logic [3:0]    offset_next;

    logic [9:0]    prev;
    logic [9:0]    aligned;
    logic [9:0]    aligned_next;
    logic          is_token;
    logic [1:0]    ctl;
    logic [7:0]    d;
    logic [7:0]    decoded;

    logic [7:0]    data_next;
    logic          valid_next;
    logic          hs_next;
    logic          vs_next;

    // ------------------------------------------------------------------
    // Stage 1: alignment. The shift keeps the slice in range for any
    // offset and only the low 10 bits are taken.
    // ------------------------------------------------------------------
    assign aligned_next = 10'({data_in, prev} >> bit_offset);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    // NOTE: the aligned word is reset along with prev so nothing captured
    // before or during reset can reach the outputs after release.
    always_ff @(posedge clk_in) begin
        if (sys_rst) begin
            prev    <= '0;
            aligned <= '0;
        end else begin
            prev    <= data_in;
            aligned <= aligned_next;
        end
    end

    // ------------------------------------------------------------------
    // Classification and data decode of the aligned word
    // ------------------------------------------------------------------
    // NOTE: every signal written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        is_token = 1'b1;
        ctl      = 2'b00;
        case (aligned)
            10'b1101010100: ctl = 2'b00;
            10'b0010101011: ctl = 2'b01;
            10'b0101010100: ctl = 2'b10;
            10'b1010101011: ctl = 2'b11;
            default:        is_token = 1'b0;
        endcase
    end

    always_comb begin
        d          = aligned[9] ? ~aligned[7:0] : aligned[7:0];
        decoded    = '0;
        decoded[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            decoded[i] = aligned[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
    end

    // ------------------------------------------------------------------
    // FSM process 1: state register (with its counters and the offset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (sys_rst) begin
            state      <= SEARCH;
            search_cnt <= '0;
            verify_cnt <= '0;
            loss_cnt   <= '0;
            bit_offset <= '0;
        end else begin
            state      <= state_next;
            search_cnt <= search_next;
            verify_cnt <= verify_next;
            loss_cnt   <= loss_next;
            bit_offset <= offset_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state;
        search_next = search_cnt;
        verify_next = verify_cnt;
        loss_next   = loss_cnt;
        offset_next = bit_offset;
        case (state)
            SEARCH: begin
                if (is_token) begin
                    state_next  = (TOKEN_LOCK <= 1) ? LOCKED : VERIFY;
                    verify_next = TW'(1);
                    loss_next   = '0;
                end else if (search_cnt == SEARCH_LAST) begin
                    search_next = '0;
                    offset_next = (bit_offset == 4'd9) ? 4'd0 : bit_offset + 4'd1;
                end else begin
                    search_next = search_cnt + 1'b1;
                end
            end
            VERIFY: begin
                if (is_token) begin
                    verify_next = verify_cnt + 1'b1;
                    if (verify_cnt == TOKEN_LAST) begin
                        state_next = LOCKED;
                        loss_next  = '0;
                    end
                end else begin
                    state_next  = SEARCH;
                    search_next = '0;
                end
            end
            LOCKED: begin
                // A token on the same cycle as loss expiry keeps the lock.
                if (is_token) begin
                    loss_next = '0;
                end else if (loss_cnt == LOSS_LAST) begin
                    state_next  = SEARCH;
                    search_next = '0;
                end else begin
                    loss_next = loss_cnt + 1'b1;
                end
            end
            default: state_next = SEARCH;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM process 3: outputs. They are qualified by the state being
    // entered so the registered outputs always agree with 'locked'.
    // ------------------------------------------------------------------
    always_comb begin
        data_next  = '0;
        valid_next = 1'b0;
        hs_next    = 1'b0;
        vs_next    = 1'b0;
        if (state_next == LOCKED) begin
            if (is_token) begin
                hs_next = ctl[0];
                vs_next = ctl[1];
            end else begin
                data_next  = decoded;
                valid_next = 1'b1;
                hs_next    = hsync;
                vs_next    = vsync;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (sys_rst) begin
            data_out  <= '0;
            rgb_valid <= 1'b0;
            hsync     <= 1'b0;
            vsync     <= 1'b0;
        end else begin
            data_out  <= data_next;
            rgb_valid <= valid_next;
            hsync     <= hs_next;
            vsync     <= vs_next;
        end
    end

    assign locked = (state == LOCKED);

`ifdef LOCK_LOSS_CNT_EN
    always_ff @(posedge clk_in) begin
        if (sys_rst) begin
            lock_loss_cnt <= '0;
        end else if (state == LOCKED && state_next == SEARCH &&
                     lock_loss_cnt != 16'hFFFF) begin
            lock_loss_cnt <= lock_loss_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// -----------------------------------------------------------------------------
// tb_tmds_decoder
//
// Self-checking bench for tmds_decoder (SEARCH_WIN=16, TOKEN_LOCK=8,
// LOSS_WIN=64). Expected output words are queued when a raw word is driven
// and compared when the word reaches the registered outputs.
// Optional feature macro: LOCK_LOSS_CNT_EN
// -----------------------------------------------------------------------------
module tb_tmds_decoder;

    localparam int SEARCH_WIN = 16;
    localparam int TOKEN_LOCK = 8;
    localparam int LOSS_WIN   = 64;

    localparam logic [9:0] TOK00 = 10'b1101010100;
    localparam logic [9:0] TOK01 = 10'b0010101011;
    localparam logic [9:0] TOK10 = 10'b0101010100;
    localparam logic [9:0] TOK11 = 10'b1010101011;

    logic        clk_in  = 1'b0;
    logic        sys_rst = 1'b1;
    logic [9:0]  data_in = '0;
    logic [7:0]  data_out;
    logic        rgb_valid;
    logic        hsync;
    logic        vsync;
    logic        locked;
    logic [3:0]  bit_offset;
`ifdef LOCK_LOSS_CNT_EN
    logic [15:0] lock_loss_cnt;
`endif

    tmds_decoder #(
        .SEARCH_WIN (SEARCH_WIN),
        .TOKEN_LOCK (TOKEN_LOCK),
        .LOSS_WIN   (LOSS_WIN)
    ) dut (
        .clk_in     (clk_in),
        .sys_rst    (sys_rst),
        .data_in    (data_in),
        .data_out   (data_out),
        .rgb_valid  (rgb_valid),
        .hsync      (hsync),
        .vsync      (vsync),
        .locked     (locked),
        .bit_offset (bit_offset)
`ifdef LOCK_LOSS_CNT_EN
        ,
        .lock_loss_cnt (lock_loss_cnt)
`endif
    );

    always #5 clk_in = ~clk_in;

    int edges = 0;
    always @(posedge clk_in) edges++;

    // Expected word layout: {locked, rgb_valid, hsync, vsync, data_out}
    typedef struct {
        int          due;
        logic [11:0] want;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model state for the locked stream
    logic m_hs      = 1'b0;
    logic m_vs      = 1'b0;
    int   since_tok = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        if (obs !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, want, $time);
        end
    endtask

    function automatic int token_code(input logic [9:0] w);
        case (w)
            TOK00:   return 0;
            TOK01:   return 1;
            TOK10:   return 2;
            TOK11:   return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [7:0] tmds_dec(input logic [9:0] w);
        logic [7:0] dd, q;
        dd   = w[7:0] ^ {8{w[9]}};
        q    = '0;
        q[0] = dd[0];
        for (int i = 1; i < 8; i++) q[i] = dd[i] ^ dd[i-1] ^ ~w[8];
        return q;
    endfunction

    // Scoreboard monitor: outputs are stable at the falling edge.
    always @(negedge clk_in) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= edges) begin
            e = sb.pop_front();
            check(e.tag, {20'h0, locked, rgb_valid, hsync, vsync, data_out}, {20'h0, e.want});
        end
    end

    // A word driven now is sampled on the next edge and appears on the
    // outputs two edges after that.
    task automatic drive_exp(input logic [9:0] w, input logic [11:0] want, input string tag);
        @(negedge clk_in);
        data_in = w;
        sb.push_back('{due: edges + 3, want: want, tag: tag});
    endtask

    task automatic send_locked(input logic [9:0] w, input string tag);
        int          code;
        logic [1:0]  c;
        logic [11:0] want;
        code = token_code(w);
        if (code >= 0) begin
            c         = 2'(code);
            since_tok = 0;
            m_hs      = c[0];
            m_vs      = c[1];
            want      = {1'b1, 1'b0, m_hs, m_vs, 8'h00};
        end else begin
            since_tok++;
            if (since_tok >= LOSS_WIN) begin
                m_hs = 1'b0;
                m_vs = 1'b0;
                want = '0;
            end else begin
                want = {1'b1, 1'b1, m_hs, m_vs, tmds_dec(w)};
            end
        end
        drive_exp(w, want, tag);
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && sb.size() > 0; i++) @(negedge clk_in);
        if (sb.size() != 0) begin
            check("sb_drain", sb.size(), 0);
            sb.delete();
        end
    endtask

    // Leaves sys_rst released at a falling edge with no non-reset edge yet.
    task automatic do_reset();
        @(negedge clk_in);
        sys_rst = 1'b1;
        data_in = '0;
        repeat (2) @(negedge clk_in);
        sys_rst = 1'b0;
    endtask

    function automatic logic [9:0] rand_data();
        logic [9:0] w;
        w = 10'($urandom);
        if (token_code(w) >= 0) w = 10'h1E3;
        return w;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0]  toks [4];
        logic [9:0]  rot3;
        logic [11:0] want;
        int          rel, t1, t2, t3, tl;
        int          seen [$];
        logic [3:0]  last_off;

        toks[0] = TOK00; toks[1] = TOK01; toks[2] = TOK10; toks[3] = TOK11;

        // ---------------- reset state ----------------
        do_reset();
        check("rst_outputs", {28'h0, locked, rgb_valid, hsync, vsync}, 0);
        check("rst_data_out", data_out, 0);
        check("rst_bit_offset", bit_offset, 0);

        // ---------------- lock on 8 aligned tokens ----------------
        for (int i = 0; i < TOKEN_LOCK; i++) begin
            want = (i == TOKEN_LOCK - 1) ? {1'b1, 1'b0, 1'b0, 1'b0, 8'h00} : 12'h000;
            drive_exp(TOK00, want, $sformatf("lock_tok%0d", i));
        end
        m_hs = 1'b0; m_vs = 1'b0; since_tok = 0;
        drain();
        check("lock_bit_offset", bit_offset, 0);

        // ---------------- decode while locked ----------------
        send_locked(10'h100, "dec_100");
        send_locked(10'h0FF, "dec_0ff");
        send_locked(TOK11,   "tok11");
        send_locked(10'h0FF, "dec_hold_sync");
        send_locked(TOK01,   "tok01");
        for (int i = 0; i < 6; i++) send_locked(rand_data(), $sformatf("dec_rand%0d", i));
        send_locked(TOK10,   "tok10");

        // ---------------- loss of lock after LOSS_WIN data words ----------------
        for (int i = 0; i < LOSS_WIN; i++) send_locked(rand_data(), $sformatf("loss_w%0d", i));
        drive_exp(10'h0FF, 12'h000, "after_loss");
        drain();
        check("loss_bit_offset", bit_offset, 0);
`ifdef LOCK_LOSS_CNT_EN
        check("lock_loss_cnt", lock_loss_cnt, 1);
`endif

        // ---------------- VERIFY abort then relock ----------------
        do_reset();
        for (int i = 0; i < 5; i++) drive_exp(toks[i % 4], 12'h000, $sformatf("vfy_tok%0d", i));
        drive_exp(10'h1A5, 12'h000, "vfy_abort");
        for (int i = 0; i < TOKEN_LOCK; i++) begin
            want = (i == TOKEN_LOCK - 1) ? {1'b1, 1'b0, 1'b1, 1'b1, 8'h00} : 12'h000;
            drive_exp(toks[i % 4], want, $sformatf("relock_tok%0d", i));
        end
        m_hs = 1'b1; m_vs = 1'b1; since_tok = 0;
        send_locked(10'h0FF, "relock_data");
        drain();
        check("relock_bit_offset", bit_offset, 0);

        // ---------------- offset search: tokens at offset 3 ----------------
        rot3 = {TOK00[6:0], TOK00[9:7]};
        do_reset();
        data_in  = rot3;
        rel      = edges;
        t1 = 0; t2 = 0; t3 = 0; tl = 0;
        last_off = 4'd0;
        for (int i = 0; i < 100 && tl == 0; i++) begin
            @(negedge clk_in);
            if (bit_offset != last_off) begin
                seen.push_back(int'(bit_offset));
                last_off = bit_offset;
                if (bit_offset == 4'd1 && t1 == 0) t1 = edges;
                if (bit_offset == 4'd2 && t2 == 0) t2 = edges;
                if (bit_offset == 4'd3 && t3 == 0) t3 = edges;
            end
            if (locked && tl == 0) tl = edges;
        end
        check("search_steps", seen.size(), 3);
        for (int i = 0; i < 3 && i < seen.size(); i++)
            check($sformatf("search_step%0d", i), seen[i], i + 1);
        check("search_t1", t1 - rel, SEARCH_WIN);
        check("search_t2", t2 - t1, SEARCH_WIN);
        check("search_t3", t3 - t2, SEARCH_WIN);
        check("search_lock_time", tl - t3, TOKEN_LOCK + 1);
        check("search_final_offset", bit_offset, 3);
        check("search_locked", locked, 1);

        // ---------------- reset pulse while locked ----------------
        @(negedge clk_in);
        sys_rst = 1'b1;
        @(negedge clk_in);
        check("pulse_locked", locked, 0);
        check("pulse_rgb_valid", rgb_valid, 0);
        check("pulse_bit_offset", bit_offset, 0);
        check("pulse_outputs", {22'h0, hsync, vsync, data_out}, 0);
        sys_rst = 1'b0;
        for (int i = 0; i < 4; i++) drive_exp(10'h0FF, 12'h000, $sformatf("post_rst%0d", i));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tmds_decoder.md
TMDS_DECODER -- requirements
Module: tmds_decoder

Interface
REQ-001 Parameter SEARCH_WIN, default 1024: cycles without a control token at one bit offset before SEARCH advances the offset.
REQ-002 Parameter TOKEN_LOCK, default 8: consecutive control tokens required in VERIFY to enter LOCKED.
REQ-003 Parameter LOSS_WIN, default 4096: cycles without a control token in LOCKED before lock is dropped.
REQ-004 Port clk_in, input, 1: pixel clock; all logic on its rising edge; one raw word per cycle.
REQ-005 Port sys_rst, input, 1: synchronous, active-high reset.
REQ-006 Port data_in, input, 10: raw deserialized TMDS word at arbitrary bit alignment.
REQ-007 Port data_out, output, 8: decoded pixel byte.
REQ-008 Port rgb_valid, output, 1: data-enable; high when data_out is a decoded video word.
REQ-009 Port hsync, output, 1: control bit C0 from the last control token.
REQ-010 Port vsync, output, 1: control bit C1 from the last control token.
REQ-011 Port locked, output, 1: high while the alignment FSM is in LOCKED.
REQ-012 Port bit_offset, output, 4: current alignment offset, 0..9.

Function
REQ-013 SHALL keep the previous raw word and form a 20-bit concat {data_in, prev}, with the aligned word being concat[bit_offset+9 : bit_offset], registered once.
REQ-014 SHALL classify the aligned word as a control token: 10'b1101010100 -> C1C0=00, 10'b0010101011 -> 01, 10'b0101010100 -> 10, 10'b1010101011 -> 11; every other word is data.
REQ-015 SHALL decode data words as follows: d = w[9] ? ~w[7:0] : w[7:0]; q[0] = d[0]; for i = 1..7, q[i] = w[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
REQ-016 SHALL have a latency of 2 clk_in cycles from sampling the raw word that completes the aligned window to the registered outputs.
REQ-017 FSM states: SEARCH, VERIFY, LOCKED.
REQ-018 SEARCH: a token moves the FSM to VERIFY with count = 1; otherwise the search counter increments, and on reaching SEARCH_WIN-1 it clears and bit_offset advances, wrapping 9 -> 0.
REQ-019 VERIFY: a token increments the count, and count == TOKEN_LOCK moves the FSM to LOCKED; a data word returns the FSM to SEARCH with the search counter cleared and bit_offset unchanged.
REQ-020 LOCKED: any token clears the loss counter; the loss counter reaching LOSS_WIN-1 moves the FSM to SEARCH with bit_offset unchanged; a token on that same cycle takes priority and lock is kept.
REQ-021 In LOCKED, a token word drives rgb_valid = 0, data_out = 0, and hsync/vsync = C0/C1.
REQ-022 In LOCKED, a data word drives rgb_valid = 1 and data_out = the decoded byte, while hsync/vsync hold their last values.
REQ-023 Outside LOCKED, data_out = 0, rgb_valid = 0, hsync = 0, vsync = 0.
REQ-024 bit_offset SHALL change only in SEARCH, and a change takes effect on the next aligned word.

Reset
REQ-025 With sys_rst high at a clock edge: state = SEARCH, bit_offset = 0, all counters = 0, prev = 0, data_out = 0, rgb_valid = 0, hsync = 0, vsync = 0, locked = 0.
REQ-026 Reset asserted mid-lock SHALL drop locked and clear the outputs on the next edge, with no pipeline residue after release.

Configuration
REQ-027 With macro LOCK_LOSS_CNT_EN defined, port lock_loss_cnt (output, 16) SHALL be present, reset to 0, increment on each LOCKED->SEARCH transition, and saturate at 16'hFFFF.
REQ-028 Without LOCK_LOSS_CNT_EN, lock_loss_cnt and its logic SHALL be absent, with all other behaviour identical.

Verification (bench parameters: SEARCH_WIN=16, TOKEN_LOCK=8, LOSS_WIN=64)
REQ-029 Reset, then 8 aligned words of 10'b1101010100 -> locked rises after the 8th token plus latency; hsync = 0, vsync = 0, bit_offset = 0.
REQ-030 Locked, then words 10'h100 and 10'h0FF -> 2 cycles later data_out = 8'h00 then 8'hFF with rgb_valid = 1; a following 10'b1010101011 -> rgb_valid = 0, hsync = 1, vsync = 1.
REQ-031 Token stream shifted so that tokens sit at offset 3 -> bit_offset steps 0 -> 1 -> 2 -> 3 at 16-cycle intervals, and locked then rises.
REQ-032 5 tokens, 1 data word, then tokens -> VERIFY aborts to SEARCH with bit_offset unchanged, and lock follows 8 further tokens.
REQ-033 Locked, then 64 data words with no token -> locked falls, outputs go to 0, and lock_loss_cnt = 1 when LOCK_LOSS_CNT_EN is defined.
REQ-034 sys_rst pulsed for 1 cycle while locked -> next edge: locked = 0, rgb_valid = 0, bit_offset = 0.
